// File: rtl/ws2812_frame_arbiter.sv
// Frame-granular arbiter sharing one WS2812 serializer between two pixel sources.
// Build option: define WS2812_FIXED_PRIO_EN for fixed priority (src0 wins ties); default is round-robin.
module ws2812_frame_arbiter #(
  parameter int unsigned NUM_LEDS   = 2,
  parameter int unsigned RES_CYCLES = 500,
  parameter int unsigned CNT_W      = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  output logic [1:0]  gnt,
  input  logic [1:0]  pix_valid,
  input  logic [47:0] pix_data,
  output logic [1:0]  pix_ready,
  output logic        ser_valid,
  output logic [23:0] ser_data,
  input  logic        ser_ready,
  output logic        frame_done,
  output logic        busy
);

  localparam int unsigned PIX_W = 24;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] LATCH  = 2'd2;

  logic [1:0]       state, state_d;
  logic [1:0]       gnt_d;
  logic [CNT_W-1:0] pix_cnt, pix_cnt_d;
  logic [CNT_W-1:0] gap_cnt, gap_cnt_d;
  logic             ser_valid_d;
  logic [PIX_W-1:0] ser_data_d;
  logic             frame_done_d;
  logic             room;
  logic             xfer;
  logic             ser_hs;
  logic             pick;
  logic [PIX_W-1:0] src_pix;
`ifndef WS2812_FIXED_PRIO_EN
  logic             last, last_d;
`endif

  // Stage can take a pixel when the frame is not complete and the stage empties this cycle
  assign room      = (pix_cnt < CNT_W'(NUM_LEDS)) && (!ser_valid || ser_ready);
  assign pix_ready = gnt & {2{room}};
  assign xfer      = |(pix_valid & pix_ready);
  assign ser_hs    = ser_valid & ser_ready;
  assign src_pix   = gnt[1] ? pix_data[47:24] : pix_data[23:0];
  assign busy      = (state != IDLE);

`ifdef WS2812_FIXED_PRIO_EN
  assign pick = ~req[0];
`else
  assign pick = (&req) ? ~last : ~req[0];
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state;
    gnt_d        = gnt;
    pix_cnt_d    = pix_cnt;
    gap_cnt_d    = gap_cnt;
    ser_valid_d  = ser_valid;
    ser_data_d   = ser_data;
    frame_done_d = 1'b0;
`ifndef WS2812_FIXED_PRIO_EN
    last_d       = last;
`endif
    case (state)
      IDLE: begin
        if (|req) begin
          state_d   = STREAM;
          gnt_d     = pick ? 2'b10 : 2'b01;
          pix_cnt_d = '0;
`ifndef WS2812_FIXED_PRIO_EN
          last_d    = pick;
`endif
        end
      end
      STREAM: begin
        if (xfer) begin
          ser_valid_d = 1'b1;
          ser_data_d  = src_pix;
          pix_cnt_d   = pix_cnt + CNT_W'(1);
        end else if (ser_hs) begin
          ser_valid_d = 1'b0;
        end
        // With the count full, the stage can only hold the final pixel of the frame
        if (ser_hs && (pix_cnt == CNT_W'(NUM_LEDS))) begin
          state_d   = LATCH;
          gnt_d     = 2'b00;
          gap_cnt_d = '0;
        end
      end
      LATCH: begin
        gap_cnt_d = gap_cnt + CNT_W'(1);
        if (gap_cnt == CNT_W'(RES_CYCLES - 1)) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt        <= 2'b00;
      pix_cnt    <= '0;
      gap_cnt    <= '0;
      ser_valid  <= 1'b0;
      ser_data   <= '0;
      frame_done <= 1'b0;
`ifndef WS2812_FIXED_PRIO_EN
      last       <= 1'b1;
`endif
    end else begin
      state      <= state_d;
      gnt        <= gnt_d;
      pix_cnt    <= pix_cnt_d;
      gap_cnt    <= gap_cnt_d;
      ser_valid  <= ser_valid_d;
      ser_data   <= ser_data_d;
      frame_done <= frame_done_d;
`ifndef WS2812_FIXED_PRIO_EN
      last       <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_ws2812_frame_arbiter.sv
// Self-checking bench for ws2812_frame_arbiter: directed frames plus randomized traffic
// checked against a frame-level model of grants, pixel order and latch timing.
module tb_ws2812_frame_arbiter;

  localparam int unsigned NUM_LEDS   = 2;
  localparam int unsigned RES_CYCLES = 500;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [1:0]  gnt;
  logic [1:0]  pix_valid;
  logic [47:0] pix_data;
  logic [1:0]  pix_ready;
  logic        ser_valid;
  logic [23:0] ser_data;
  logic        ser_ready;
  logic        frame_done;
  logic        busy;

  ws2812_frame_arbiter #(
    .NUM_LEDS  (NUM_LEDS),
    .RES_CYCLES(RES_CYCLES),
    .CNT_W     (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .pix_ready (pix_ready),
    .ser_valid (ser_valid),
    .ser_data  (ser_data),
    .ser_ready (ser_ready),
    .frame_done(frame_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state: granted source, pixels of the current frame, one-entry stage contents
  int          m_last = 1;
  int          g;
  int          taken;
  int          sent;
  bit          stage_full;
  logic [23:0] stage_data;
  logic [23:0] pixels [NUM_LEDS];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick_src(input logic [1:0] r, input int last);
`ifdef WS2812_FIXED_PRIO_EN
    if (last < 0) return 0;
    return r[0] ? 0 : 1;
`else
    if (r == 2'b11) return 1 - last;
    return r[0] ? 0 : 1;
`endif
  endfunction

  function automatic logic [1:0] onehot(input int idx);
    return (idx == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < NUM_LEDS; i++) pixels[i] = 24'($urandom);
  endtask

  // Called at a negedge with the arbiter idle (or in its frame_done cycle)
  task automatic start_frame(input logic [1:0] r);
    req = r;
    g = pick_src(r, m_last);
    m_last = g;
    taken = 0;
    sent = 0;
    stage_full = 1'b0;
    @(negedge clk);
    check("gnt_on_grant", 32'(gnt), 32'(onehot(g)));
    check("busy_stream", 32'(busy), 32'd1);
    check("frame_done_low", 32'(frame_done), 32'd0);
  endtask

  // mode 0: full rate, 1: random, 2: serializer stall 7 cycles, 3: req drop + source stall
  task automatic stream(input int mode, input int max_cyc, output bit done, output int cyc);
    logic        vld, rdy, exp_r, hs;
    logic [1:0]  pv;
    logic [23:0] d_g;
    done = 1'b0;
    cyc = 0;
    for (int c = 0; c < max_cyc; c++) begin
      case (mode)
        0:       begin vld = 1'b1; rdy = 1'b1; end
        1:       begin vld = ($urandom % 4) != 0; rdy = ($urandom % 3) != 0; end
        2:       begin vld = 1'b1; rdy = !(c >= 1 && c <= 7); end
        default: begin vld = (c == 0) || (c >= 6); rdy = 1'b1; end
      endcase
      if (mode == 3 && c == 1) req = 2'b00;
      d_g = (taken < NUM_LEDS) ? pixels[taken] : 24'($urandom);
      pv = 2'($urandom);
      pv[g] = vld;
      pix_valid = pv;
      pix_data = (g == 1) ? {d_g, 24'($urandom)} : {24'($urandom), d_g};
      ser_ready = rdy;
      #1;
      exp_r = (taken < NUM_LEDS) && (!stage_full || rdy);
      check("gnt_hold", 32'(gnt), 32'(onehot(g)));
      check("pix_ready", 32'(pix_ready), 32'(exp_r ? onehot(g) : 2'b00));
      check("ser_valid", 32'(ser_valid), 32'(stage_full));
      if (stage_full) check("ser_data", 32'(ser_data), 32'(stage_data));
      hs = stage_full && rdy;
      if (vld && exp_r) begin
        stage_full = 1'b1;
        stage_data = pixels[taken];
        taken++;
      end else if (hs) begin
        stage_full = 1'b0;
      end
      if (hs) sent++;
      @(negedge clk);
      cyc++;
      if (sent == NUM_LEDS) begin
        done = 1'b1;
        break;
      end
    end
  endtask

  // Walks the latch gap; next_req is raised at a random point inside it
  task automatic latch_phase(input logic [1:0] next_req);
    int fd_at = -1;
    int bad = 0;
    int req_k;
    req_k = $urandom_range(0, RES_CYCLES - 1);
    check("latch_gnt_clear", 32'(gnt), 32'd0);
    check("latch_ser_valid", 32'(ser_valid), 32'd0);
    check("latch_busy", 32'(busy), 32'd1);
    for (int k = 0; k <= RES_CYCLES; k++) begin
      if (frame_done === 1'b1 && fd_at < 0) fd_at = k;
      if (k < RES_CYCLES && (busy !== 1'b1 || gnt !== 2'b00 || ser_valid !== 1'b0)) bad++;
      if (k == req_k) req = next_req;
      pix_valid = 2'($urandom);
      pix_data = {24'($urandom), 24'($urandom)};
      ser_ready = 1'($urandom);
      #1;
      if (pix_ready !== 2'b00) bad++;
      if (k < RES_CYCLES) @(negedge clk);
    end
    check("latch_bad_cycles", 32'(bad), 32'd0);
    check("frame_done_at", 32'(fd_at), 32'(RES_CYCLES));
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_gnt_not_yet", 32'(gnt), 32'd0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      req = 2'b00;
      @(negedge clk);
      check("idle_gnt", 32'(gnt), 32'd0);
      check("idle_busy_low", 32'(busy), 32'd0);
      check("idle_frame_done", 32'(frame_done), 32'd0);
    end
  endtask

  initial begin
    bit         done;
    int         cyc;
    logic [1:0] r, nxt;
    bit         hold;

    rst_n = 1'b0;
    req = 2'b00;
    pix_valid = 2'b00;
    pix_data = '0;
    ser_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_ser_valid", 32'(ser_valid), 32'd0);
    check("rst_ser_data", 32'(ser_data), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pix_ready", 32'(pix_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single source, full rate, known pixels
    pixels[0] = 24'hFF0000;
    pixels[1] = 24'hFFFF00;
    start_frame(2'b01);
    stream(0, 10, done, cyc);
    check("frame1_done", 32'(done), 32'd1);
    check("full_rate_cycles", 32'(cyc), 32'(NUM_LEDS + 1));
    latch_phase(2'b11);

    // Both requesting across consecutive frames
    for (int i = 0; i < 4; i++) begin
      fill_random();
      start_frame(2'b11);
      stream(1, 400, done, cyc);
      check("tie_frame_done", 32'(done), 32'd1);
      latch_phase((i == 3) ? 2'b01 : 2'b11);
    end

    // Serializer back-pressure
    fill_random();
    start_frame(2'b01);
    stream(2, 50, done, cyc);
    check("stall_frame_done", 32'(done), 32'd1);
    latch_phase(2'b01);

    // Request dropped after the first pixel, source stalls
    fill_random();
    start_frame(2'b01);
    stream(3, 50, done, cyc);
    check("drop_frame_done", 32'(done), 32'd1);
    latch_phase(2'b00);
    idle_cycles(2);

    // Randomized traffic
    nxt = 2'($urandom_range(1, 3));
    for (int f = 0; f < 10; f++) begin
      r = nxt;
      nxt = 2'($urandom_range(1, 3));
      hold = ($urandom % 3) != 0;
      fill_random();
      start_frame(r);
      stream(1, 400, done, cyc);
      check("rand_frame_done", 32'(done), 32'd1);
      latch_phase(hold ? nxt : 2'b00);
      if (!hold) idle_cycles($urandom_range(1, 3));
    end

    // Asynchronous reset in the middle of a frame
    fill_random();
    start_frame(2'b01);
    stream(0, 1, done, cyc);
    check("partial_not_done", 32'(done), 32'd0);
    rst_n = 1'b0;
    req = 2'b00;
    #1;
    check("arst_gnt", 32'(gnt), 32'd0);
    check("arst_ser_valid", 32'(ser_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_pix_ready", 32'(pix_ready), 32'd0);
    m_last = 1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill_random();
    start_frame(2'b10);
    stream(1, 400, done, cyc);
    check("post_rst_frame_done", 32'(done), 32'd1);
    latch_phase(2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
